// File: rtl/pipeline_stall_scheduler_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and its miss FSM.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        RESUME    = 2'd3
    } miss_state_e;

    localparam logic MEM_WR = 1'b1;
    localparam logic MEM_RD = 1'b0;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TMO_W           = 8;

endpackage

// File: rtl/pipeline_stall_scheduler_miss_fsm.sv
// Data-cache miss sequencer: writeback, refill, resume; owns the phase timeout and start/fill pulses.
// freeze_o is combinational so the pipeline holds in the very cycle the miss is detected.
module miss_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_req_i,
    input  logic cache_hit_i,
    input  logic cache_dirty_i,
    input  logic mem_ack_i,
    output logic freeze_o,
    output logic mem_start_o,
    output logic mem_wr_o,
    output logic cache_fill_o,
    output logic busy_o,
    output logic error_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    miss_state_e      state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_start_q, mem_start_d;
    logic             mem_wr_q, mem_wr_d;
    logic             cache_fill_q, cache_fill_d;
    logic             error_q, error_d;

    logic miss_now;
    logic in_phase;
    logic timeout_now;

    always_comb begin
        miss_now    = (state_q == IDLE) & mem_req_i & ~cache_hit_i;
        in_phase    = (state_q == WRITEBACK) | (state_q == REFILL);
        // The TIMEOUT-th cycle of a phase is flagged as it is entered, not one cycle later.
        timeout_now = in_phase & (tmo_cnt_q == TMO_LAST);

        state_d      = state_q;
        tmo_cnt_d    = (in_phase && tmo_cnt_q != '1) ? tmo_cnt_q + TMO_W'(1) : tmo_cnt_q;
        mem_start_d  = 1'b0;
        mem_wr_d     = mem_wr_q;
        cache_fill_d = 1'b0;
        error_d      = error_q | timeout_now;

        case (state_q)
            IDLE: begin
                if (miss_now) begin
                    state_d     = cache_dirty_i ? WRITEBACK : REFILL;
                    tmo_cnt_d   = '0;
                    mem_start_d = 1'b1;
                    mem_wr_d    = cache_dirty_i ? MEM_WR : MEM_RD;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = REFILL;
                    tmo_cnt_d   = '0;
                    mem_start_d = 1'b1;
                    mem_wr_d    = MEM_RD;
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    state_d      = RESUME;
                    cache_fill_d = 1'b1;
                end
            end
            RESUME: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tmo_cnt_q    <= '0;
            mem_start_q  <= 1'b0;
            mem_wr_q     <= MEM_RD;
            cache_fill_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            mem_start_q  <= mem_start_d;
            mem_wr_q     <= mem_wr_d;
            cache_fill_q <= cache_fill_d;
            error_q      <= error_d;
        end
    end

    assign freeze_o     = miss_now | (state_q != IDLE);
    assign busy_o       = (state_q != IDLE);
    assign mem_start_o  = mem_start_q;
    assign mem_wr_o     = mem_wr_q;
    assign cache_fill_o = cache_fill_q;
    assign error_o      = error_q | timeout_now;

endmodule

// File: rtl/pipeline_stall_scheduler.sv
// Merges cache-miss freeze, branch flush and load-use stall into per-stage enables, flush and bubble.
// Priority freeze > branch flush > load-use; also counts cycles where the PC is held.
module pipeline_stall_scheduler
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_i,
    input  logic             branch_flush_i,
    input  logic             mem_req_i,
    input  logic             cache_hit_i,
    input  logic             cache_dirty_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_write_o,
    output logic             mem_start_o,
    output logic             mem_wr_o,
    output logic             cache_fill_o,
    output logic             busy_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    logic             freeze;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    miss_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_miss_fsm (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_req_i     (mem_req_i),
        .cache_hit_i   (cache_hit_i),
        .cache_dirty_i (cache_dirty_i),
        .mem_ack_i     (mem_ack_i),
        .freeze_o      (freeze),
        .mem_start_o   (mem_start_o),
        .mem_wr_o      (mem_wr_o),
        .cache_fill_o  (cache_fill_o),
        .busy_o        (busy_o),
        .error_o       (error_o)
    );

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_write_o  = 1'b1;
        // A branch seen while frozen stays in ID and re-requests once the freeze lifts.
        if (freeze) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_write_o = 1'b0;
        end else if (branch_flush_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (load_use_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_write_o && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_scheduler.sv
// Scoreboard bench: a phase-level reference model predicts each cycle's outputs; a monitor compares them.
module tb_pipeline_stall_scheduler;

    localparam int TMO   = 4;
    localparam int CNT_W = 8;
    localparam int SMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use = 1'b0, branch_flush = 1'b0, mem_req = 1'b0;
    logic cache_hit = 1'b0, cache_dirty = 1'b0, mem_ack = 1'b0;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_write;
    logic mem_start, mem_wr, cache_fill, busy, error;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_stall_scheduler #(
        .TIMEOUT (TMO),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .load_use_i     (load_use),
        .branch_flush_i (branch_flush),
        .mem_req_i      (mem_req),
        .cache_hit_i    (cache_hit),
        .cache_dirty_i  (cache_dirty),
        .mem_ack_i      (mem_ack),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .pipe_write_o   (pipe_write),
        .mem_start_o    (mem_start),
        .mem_wr_o       (mem_wr),
        .cache_fill_o   (cache_fill),
        .busy_o         (busy),
        .error_o        (error),
        .stall_cycles_o (stall_cycles)
    );

    typedef struct packed {
        logic             pc_w;
        logic             ifid_w;
        logic             ifid_fl;
        logic             bub;
        logic             pipe_w;
        logic             start;
        logic             wr;
        logic             fill;
        logic             busy;
        logic             err;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle_no = 0;

    // Reference model state: phase 0=none 1=writeback 2=refill 3=resume; age = completed cycles in phase.
    int ph = 0;
    int age = 0;
    bit m_start = 0, m_wr = 0, m_err = 0;
    int stalls = 0;

    task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle_no, act, exp_v);
        end
    endtask

    task automatic cyc(input bit r, input bit lu, input bit bf, input bit req,
                       input bit hit, input bit dirty, input bit ack);
        exp_t e;
        bit   miss, frz;
        @(posedge clk);
        #1;
        rst = r; load_use = lu; branch_flush = bf; mem_req = req;
        cache_hit = hit; cache_dirty = dirty; mem_ack = ack;

        miss      = (ph == 0) && req && !hit;
        frz       = miss || (ph != 0);
        e.pc_w    = !frz && (bf || !lu);
        e.ifid_w  = e.pc_w;
        e.ifid_fl = !frz && bf;
        e.bub     = !frz && (bf || lu);
        e.pipe_w  = !frz;
        e.start   = m_start;
        e.wr      = m_wr;
        e.fill    = (ph == 3);
        e.busy    = (ph != 0);
        e.err     = m_err || ((ph == 1 || ph == 2) && age >= TMO - 1);
        e.stall   = CNT_W'(stalls);
        expq.push_back(e);

        if (r) begin
            ph = 0; age = 0; m_start = 0; m_wr = 0; m_err = 0; stalls = 0;
        end else begin
            if (!e.pc_w && stalls < SMAX) stalls++;
            m_err   = e.err;
            m_start = 0;
            case (ph)
                0: if (miss) begin ph = dirty ? 1 : 2; age = 0; m_start = 1; m_wr = dirty; end
                1: if (ack) begin ph = 2; age = 0; m_start = 1; m_wr = 0; end else age++;
                2: if (ack) ph = 3; else age++;
                default: ph = 0;
            endcase
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pc_write",    CNT_W'(pc_write),    CNT_W'(e.pc_w));
                chk("ifid_write",  CNT_W'(ifid_write),  CNT_W'(e.ifid_w));
                chk("ifid_flush",  CNT_W'(ifid_flush),  CNT_W'(e.ifid_fl));
                chk("idex_bubble", CNT_W'(idex_bubble), CNT_W'(e.bub));
                chk("pipe_write",  CNT_W'(pipe_write),  CNT_W'(e.pipe_w));
                chk("mem_start",   CNT_W'(mem_start),   CNT_W'(e.start));
                if (e.start) chk("mem_wr", CNT_W'(mem_wr), CNT_W'(e.wr));
                chk("cache_fill",  CNT_W'(cache_fill),  CNT_W'(e.fill));
                chk("busy",        CNT_W'(busy),        CNT_W'(e.busy));
                chk("error",       CNT_W'(error),       CNT_W'(e.err));
                chk("stall_cycles", stall_cycles,       e.stall);
            end
        end
    end

    initial begin
        @(posedge clk);
        // args: rst, load_use, branch_flush, mem_req, hit, dirty, ack
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // clean miss, ack in third refill cycle, replay hits
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);

        // dirty miss: writeback acked late, refill acked in its start cycle
        cyc(0, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);

        // branch held during a refill is suppressed, then honoured after release
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);

        // timeout during refill, late ack completes it
        cyc(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);

        // reset abandons a refill in progress
        cyc(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);

        // stall counter saturation
        for (int i = 0; i < SMAX + 20; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 499) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 1) == 0,
                $urandom_range(0, 1) == 0,
                $urandom_range(0, 1) == 0,
                $urandom_range(0, 3) == 0);
        end

        repeat (3) @(posedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_scheduler.md
Name: pipeline_stall_scheduler

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Merges three stall/flush sources into one consistent set of per-stage write-enable, flush and bubble controls:
  - load-use hazard request from hazard detection;
  - branch-resolved-in-ID flush request;
  - multi-cycle data-cache miss handling in MEM.
- Owns the cache-miss state machine: writeback, then refill, then a resume handshake.
- Also keeps a stall-cycle counter and a sticky memory-timeout error flag.

Parameters:
- TIMEOUT, 255: max cycles spent in a WRITEBACK or REFILL phase before error_o sets; 8-bit counter range.
- CNT_W, 32: width of stall_cycles_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- load_use_i  in  1  load-use hazard (MemRead in ID/EX and rd matches rs1/rs2 in IF/ID).
- branch_flush_i  in  1  branch taken/resolved in ID.
- mem_req_i  in  1  MEM-stage instruction accesses dcache this cycle.
- cache_hit_i  in  1  dcache tag hit, valid with mem_req_i.
- cache_dirty_i  in  1  victim line dirty, valid with a miss.
- mem_ack_i  in  1  backing memory completed the current transfer (1-cycle pulse).
- pc_write_o  out  1  PC register write enable.
- ifid_write_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  IF/ID clear to NOP.
- idex_bubble_o  out  1  insert NOP control into ID/EX.
- pipe_write_o  out  1  write enable for ID/EX, EX/MEM, MEM/WB.
- mem_start_o  out  1  start pulse to backing memory.
- mem_wr_o  out  1  current transfer is a writeback (1) or refill (0); valid with mem_start_o.
- cache_fill_o  out  1  write refilled line into dcache, clear dirty.
- busy_o  out  1  miss FSM not IDLE.
- error_o  out  1  sticky timeout flag.
- stall_cycles_o  out  CNT_W  count of cycles with pc_write_o==0.

Behaviour:
- Reset (rst_i sampled high):
  - FSM=IDLE; timeout counter=0; stall_cycles_o=0; error_o=0.
  - Registered pulses mem_start_o, cache_fill_o =0.
  - Reset mid-miss abandons the transfer; no cache_fill_o is issued.
- miss_now = mem_req_i & ~cache_hit_i while in IDLE.
- freeze = miss_now | (state != IDLE). Combinational, so it is asserted in the detection cycle.
- Output priority: freeze > branch_flush > load_use.
  - freeze:
    - pc_write_o=0, ifid_write_o=0, pipe_write_o=0;
    - ifid_flush_o=0, idex_bubble_o=0.
    - A branch flush during freeze is suppressed. The branch stays frozen in ID and re-requests after release.
  - else branch_flush_i:
    - pc_write_o=1, ifid_write_o=1, ifid_flush_o=1;
    - idex_bubble_o=1, pipe_write_o=1.
    - Overrides a simultaneous load_use_i.
  - else load_use_i:
    - pc_write_o=0, ifid_write_o=0, ifid_flush_o=0;
    - idex_bubble_o=1, pipe_write_o=1.
  - else: all enables 1; flush and bubble 0.
- FSM transitions:
  - IDLE: on miss_now, go to WRITEBACK if cache_dirty_i, else REFILL.
  - WRITEBACK:
    - mem_start_o=1, mem_wr_o=1 in its first cycle only.
    - On mem_ack_i, go to REFILL.
  - REFILL:
    - mem_start_o=1, mem_wr_o=0 in its first cycle only.
    - On mem_ack_i, go to RESUME.
  - RESUME:
    - cache_fill_o=1 for this single cycle; freeze still held.
    - Go to IDLE next cycle. The replayed access must then hit, and freeze drops in that cycle.
- Ack handling:
  - mem_ack_i is accepted in any cycle of WRITEBACK/REFILL, including the start cycle.
  - It is ignored in IDLE/RESUME.
- Timeout counter:
  - Clears on every phase entry; increments each cycle in WRITEBACK/REFILL.
  - When it reaches TIMEOUT without an ack, error_o sets (sticky until reset).
  - The FSM keeps waiting after timeout.
- Stall counter:
  - Increments when pc_write_o==0.
  - Saturates at all-ones; no wrap.
- busy_o=1 in WRITEBACK, REFILL, RESUME.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the FSM state enum: IDLE, WRITEBACK, REFILL, RESUME;
  - the MEM_WR / MEM_RD constants;
  - the TIMEOUT default.
- One natural sub-module: miss_fsm, containing the FSM, timeout counter and pulse generation.
- The top level holds the priority merge and the stall counter.

Test Plan:
- Load-use only (load_use_i=1 for 1 cycle) -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, pipe_write_o=1; stall_cycles_o 0->1.
- load_use_i=1 and branch_flush_i=1 together -> ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1; stall_cycles_o unchanged.
- Clean miss: mem_req_i=1, cache_hit_i=0, dirty=0 at cycle T; ack at T+3:
  - freeze from T;
  - mem_start_o=1, mem_wr_o=0 at T+1 only;
  - RESUME at T+4 with cache_fill_o=1;
  - IDLE at T+5; replay with hit releases freeze at T+5.
- Dirty miss -> WRITEBACK start pulse with mem_wr_o=1; after ack, REFILL start pulse with mem_wr_o=0. Exactly two mem_start_o pulses, one cache_fill_o.
- branch_flush_i=1 during REFILL -> ifid_flush_o stays 0. After release, with branch_flush_i still 1, ifid_flush_o=1.
- No ack for TIMEOUT=4 cycles (override) -> error_o=1 at the 4th REFILL cycle and stays 1. Late ack completes the refill. rst_i=1 mid-REFILL -> IDLE, error_o=0, no cache_fill_o.
